// File: rtl/serial_tx_if.sv
// Producer-to-transmitter word handshake for the single-wire serial link.
// The producer drives tx_valid/tx_data; the transmitter drives tx_ready.
interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              tx_ready;

  modport master (output tx_valid, output tx_data, input  tx_ready);
  modport slave  (input  tx_valid, input  tx_data, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// Parallel-in, serial-out frame transmitter.
// Frame: start, DATA_W data bits LSB-first, optional even parity, stop; CLKS_PER_BIT clocks per bit.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic         clk,
  input  logic         reset,
  serial_tx_if.slave   tx,
  output logic         tx_out,
  output logic         busy,
  output logic         done
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] word);
    return ^word;
  endfunction

  state_t            state_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] shift_r;
  logic              parity_r;
  logic              bit_end_s;

  // Last clock of the current serial bit.
  assign bit_end_s = (div_cnt_r == DIV_LAST);

  // Frame sequencer; every output is registered so tx_out never sees input glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      div_cnt_r   <= {DIV_W{1'b0}};
      bit_cnt_r   <= {BIT_W{1'b0}};
      shift_r     <= {DATA_W{1'b0}};
      parity_r    <= 1'b0;
      tx_out      <= 1'b1;
      tx.tx_ready <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_r != IDLE) begin
        div_cnt_r <= bit_end_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
      end else begin
        div_cnt_r <= {DIV_W{1'b0}};
      end
      case (state_r)
        IDLE: begin
          if (tx.tx_valid && tx.tx_ready) begin
            shift_r     <= tx.tx_data;
            parity_r    <= even_parity(tx.tx_data);
            bit_cnt_r   <= {BIT_W{1'b0}};
            state_r     <= START;
            tx_out      <= 1'b0;
            tx.tx_ready <= 1'b0;
            busy        <= 1'b1;
          end else begin
            tx_out      <= 1'b1;
            tx.tx_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_r <= DATA;
            tx_out  <= shift_r[0];
          end
        end
        DATA: begin
          if (bit_end_s) begin
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_r <= {BIT_W{1'b0}};
              if (PARITY_EN != 0) begin
                state_r <= PARITY;
                tx_out  <= parity_r;
              end else begin
                state_r <= STOP;
                tx_out  <= 1'b1;
              end
            end else begin
              // Next bit comes from position 1 before the shift lands.
              bit_cnt_r <= bit_cnt_r + BIT_W'(1);
              shift_r   <= shift_r >> 1;
              tx_out    <= shift_r[1];
            end
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            state_r <= STOP;
            tx_out  <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            state_r     <= IDLE;
            tx_out      <= 1'b1;
            tx.tx_ready <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          tx_out      <= 1'b1;
          tx.tx_ready <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: default configuration plus a no-parity, one-clock-per-bit instance.
module tb_serial_tx;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tx_out0, busy0, done0;
  logic tx_out1, busy1, done1;
  int   checks = 0;
  int   failures = 0;

  logic cap_out [0:95];
  logic cap_rdy [0:95];
  logic cap_busy[0:95];
  logic cap_done[0:95];

  always #5 clk = ~clk;

  serial_tx_if #(.DATA_W(8)) if0 ();
  serial_tx_if #(.DATA_W(8)) if1 ();

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
    .clk(clk), .reset(reset), .tx(if0), .tx_out(tx_out0), .busy(busy0), .done(done0));

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut1 (
    .clk(clk), .reset(reset), .tx(if1), .tx_out(tx_out1), .busy(busy1), .done(done1));

  // Records dut0 outputs on n consecutive falling edges; index 0 is the first frame cycle.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_out[i]  = tx_out0;
      cap_rdy[i]  = if0.tx_ready;
      cap_busy[i] = busy0;
      cap_done[i] = done0;
    end
  endtask

  task automatic start_word(input logic [7:0] d);
    @(posedge clk); #1;
    if0.tx_valid = 1'b1;
    if0.tx_data  = d;
    @(posedge clk); #1;
    if0.tx_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx_out0 !== 1'b1 || if0.tx_ready !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut0: got out=%b rdy=%b busy=%b done=%b required 1 1 0 0",
               tx_out0, if0.tx_ready, busy0, done0);
    end
    checks++;
    if (tx_out1 !== 1'b1 || if1.tx_ready !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_dut1: got out=%b rdy=%b busy=%b done=%b required 1 1 0 0",
               tx_out1, if1.tx_ready, busy1, done1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_frame_a5;
    logic [10:0] exp_bits;
    exp_bits = 11'b10101001010;
    start_word(8'hA5);
    capture(46);
    for (int i = 0; i < 44; i++) begin
      checks++;
      if (cap_out[i] !== exp_bits[i/4]) begin
        failures++;
        $display("FAIL a5_tx_out cycle %0d: got %b required %b", i, cap_out[i], exp_bits[i/4]);
      end
      checks++;
      if (cap_rdy[i] !== 1'b0 || cap_busy[i] !== 1'b1 || cap_done[i] !== 1'b0) begin
        failures++;
        $display("FAIL a5_flags cycle %0d: got rdy=%b busy=%b done=%b required 0 1 0",
                 i, cap_rdy[i], cap_busy[i], cap_done[i]);
      end
    end
    checks++;
    if (cap_done[44] !== 1'b1 || cap_rdy[44] !== 1'b1 || cap_busy[44] !== 1'b0 || cap_out[44] !== 1'b1) begin
      failures++;
      $display("FAIL a5_done_cycle: got done=%b rdy=%b busy=%b out=%b required 1 1 0 1",
               cap_done[44], cap_rdy[44], cap_busy[44], cap_out[44]);
    end
    checks++;
    if (cap_done[45] !== 1'b0) begin
      failures++;
      $display("FAIL a5_done_width: got done=%b one cycle later, required 0", cap_done[45]);
    end
  endtask

  task automatic test_parity;
    logic [10:0] exp_07;
    logic [10:0] exp_00;
    exp_07 = 11'b11000001110;
    exp_00 = 11'b10000000000;
    start_word(8'h07);
    capture(46);
    for (int i = 0; i < 44; i++) begin
      checks++;
      if (cap_out[i] !== exp_07[i/4]) begin
        failures++;
        $display("FAIL parity07_tx_out cycle %0d: got %b required %b", i, cap_out[i], exp_07[i/4]);
      end
    end
    start_word(8'h00);
    capture(46);
    for (int i = 0; i < 44; i++) begin
      checks++;
      if (cap_out[i] !== exp_00[i/4]) begin
        failures++;
        $display("FAIL parity00_tx_out cycle %0d: got %b required %b", i, cap_out[i], exp_00[i/4]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [10:0] exp_3c;
    logic [10:0] exp_c3;
    int          pulses;
    exp_3c = 11'b10001111000;
    exp_c3 = 11'b10110000110;
    @(posedge clk); #1;
    if0.tx_valid = 1'b1;
    if0.tx_data  = 8'h3C;
    @(posedge clk); #1;
    if0.tx_data  = 8'hC3;
    capture(90);
    if0.tx_valid = 1'b0;
    for (int i = 0; i < 44; i++) begin
      checks++;
      if (cap_out[i] !== exp_3c[i/4]) begin
        failures++;
        $display("FAIL b2b_first cycle %0d: got %b required %b", i, cap_out[i], exp_3c[i/4]);
      end
      checks++;
      if (cap_out[45+i] !== exp_c3[i/4]) begin
        failures++;
        $display("FAIL b2b_second cycle %0d: got %b required %b", 45 + i, cap_out[45+i], exp_c3[i/4]);
      end
    end
    pulses = 0;
    for (int i = 0; i < 90; i++) pulses += int'(cap_done[i] === 1'b1);
    checks++;
    if (cap_done[44] !== 1'b1 || cap_done[89] !== 1'b1 || pulses != 2) begin
      failures++;
      $display("FAIL b2b_done: got done@44=%b done@89=%b pulses=%0d required 1 1 2",
               cap_done[44], cap_done[89], pulses);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_ignore_while_busy;
    logic [10:0] exp_12;
    exp_12 = 11'b10000100100;
    start_word(8'h12);
    fork
      capture(48);
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge clk); #1;
          if0.tx_valid = (k % 2 == 0);
          if0.tx_data  = 8'hFF;
        end
        @(posedge clk); #1;
        if0.tx_valid = 1'b0;
      end
    join
    for (int i = 0; i < 44; i++) begin
      checks++;
      if (cap_out[i] !== exp_12[i/4]) begin
        failures++;
        $display("FAIL busy_ignore_tx_out cycle %0d: got %b required %b", i, cap_out[i], exp_12[i/4]);
      end
    end
    checks++;
    if (cap_done[44] !== 1'b1 || cap_busy[45] !== 1'b0 || cap_busy[47] !== 1'b0 || cap_out[47] !== 1'b1) begin
      failures++;
      $display("FAIL busy_ignore_tail: got done@44=%b busy@45=%b busy@47=%b out@47=%b required 1 0 0 1",
               cap_done[44], cap_busy[45], cap_busy[47], cap_out[47]);
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] exp_5a;
    int          pulses;
    exp_5a = 11'b10010110100;
    start_word(8'hA5);
    repeat (18) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (tx_out0 !== 1'b1 || if0.tx_ready !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_immediate: got out=%b rdy=%b busy=%b done=%b required 1 1 0 0",
               tx_out0, if0.tx_ready, busy0, done0);
    end
    #2 reset = 1'b0;
    capture(30);
    pulses = 0;
    for (int i = 0; i < 30; i++) pulses += int'(cap_done[i] === 1'b1 || cap_out[i] !== 1'b1 || cap_busy[i] !== 1'b0);
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL midreset_quiet: got %0d idle-cycle anomalies, required 0", pulses);
    end
    start_word(8'h5A);
    capture(46);
    for (int i = 0; i < 44; i++) begin
      checks++;
      if (cap_out[i] !== exp_5a[i/4]) begin
        failures++;
        $display("FAIL midreset_5a cycle %0d: got %b required %b", i, cap_out[i], exp_5a[i/4]);
      end
    end
    checks++;
    if (cap_done[44] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_5a_done: got %b required 1", cap_done[44]);
    end
  endtask

  task automatic test_no_parity_fast;
    logic [9:0] exp_81;
    exp_81 = 10'b1100000010;
    @(posedge clk); #1;
    if1.tx_valid = 1'b1;
    if1.tx_data  = 8'h81;
    @(posedge clk); #1;
    if1.tx_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i < 10) begin
        checks++;
        if (tx_out1 !== exp_81[i] || busy1 !== 1'b1 || done1 !== 1'b0) begin
          failures++;
          $display("FAIL fast81 cycle %0d: got out=%b busy=%b done=%b required %b 1 0",
                   i, tx_out1, busy1, done1, exp_81[i]);
        end
      end else begin
        checks++;
        if (done1 !== (i == 10) || busy1 !== 1'b0 || tx_out1 !== 1'b1) begin
          failures++;
          $display("FAIL fast81_end cycle %0d: got done=%b busy=%b out=%b required %b 0 1",
                   i, done1, busy1, tx_out1, (i == 10));
        end
      end
    end
  endtask

  initial begin
    if0.tx_valid = 1'b0;
    if0.tx_data  = 8'h00;
    if1.tx_valid = 1'b0;
    if1.tx_data  = 8'h00;
    test_reset();
    test_frame_a5();
    test_parity();
    test_back_to_back();
    test_ignore_while_busy();
    test_reset_mid_frame();
    test_no_parity_fast();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
